// File: rtl/add_sequencer.sv
// add_sequencer: arbitrates two requesters onto one external 8-bit
// ripple-carry adder and performs an NBYTES-wide addition one byte per cycle.
// Byte 0 (least significant) goes first. The carry of each byte is fed into
// the next byte. The finished sum and its final carry-out stay on
// Result/CoutOut until the next operation starts overwriting them.
// NBYTES must be in the range 1..8.
module add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Req0,
  input  logic                Req1,
  input  logic [8*NBYTES-1:0] A0,
  input  logic [8*NBYTES-1:0] B0,
  input  logic [8*NBYTES-1:0] A1,
  input  logic [8*NBYTES-1:0] B1,
  input  logic                Cin0,
  input  logic                Cin1,
  output logic                Gnt0,
  output logic                Gnt1,
  output logic                Done0,
  output logic                Done1,
  output logic [8*NBYTES-1:0] Result,
  output logic                CoutOut,
  output logic                Busy,
  output logic [7:0]          AddA,
  output logic [7:0]          AddB,
  output logic                AddCin,
  input  logic [7:0]          AddS,
  input  logic                AddCout
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Extract byte number i_idx of a W-bit operand.
  function automatic logic [7:0] f_get_byte(input logic [W-1:0] i_v, input logic [CW-1:0] i_idx);
    logic [7:0] v_b;
    v_b = 8'd0;
    for (int i = 0; i < NBYTES; i++) begin
      v_b = v_b | ((i_idx == CW'(i)) ? i_v[8*i +: 8] : 8'd0);
    end
    return v_b;
  endfunction

  // Replace byte number i_idx of a W-bit word and leave the other bytes alone.
  function automatic logic [W-1:0] f_put_byte(input logic [W-1:0] i_v, input logic [CW-1:0] i_idx,
                                              input logic [7:0] i_b);
    logic [W-1:0] v_o;
    v_o = i_v;
    for (int i = 0; i < NBYTES; i++) begin
      v_o[8*i +: 8] = (i_idx == CW'(i)) ? i_b : i_v[8*i +: 8];
    end
    return v_o;
  endfunction

  // FSM state
  state_t          r_state;
  state_t          w_state_nxt;

  // Arbitration
  logic            r_ptr;        // requester that wins a tie
  logic            r_owner;      // requester currently being served
  logic            w_req_any;
  logic            w_pick;
  logic            w_owner_nxt;

  // Datapath
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_result;
  logic            r_cout;

  // Registered status outputs and their next values
  logic            r_gnt0;
  logic            r_gnt1;
  logic            r_done0;
  logic            r_done1;
  logic            r_busy;
  logic            w_gnt0_nxt;
  logic            w_gnt1_nxt;
  logic            w_done0_nxt;
  logic            w_done1_nxt;
  logic            w_busy_nxt;

  // Pick a requester: a lone request wins. On a tie, the round-robin pointer decides.
  always_comb begin
    w_req_any = Req0 | Req1;
    if (Req0 && Req1) begin
      w_pick = r_ptr;
    end else if (Req1) begin
      w_pick = 1'b1;
    end else begin
      w_pick = 1'b0;
    end
  end

  // FSM state register; reset forces IDLE regardless of pending requests.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: requests are only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_any) begin
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state, so grant/done/busy can be registered
  // and still line up with the state they describe.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_owner_nxt = w_pick;
    end else begin
      w_owner_nxt = r_owner;
    end
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_gnt0_nxt  = w_busy_nxt & ~w_owner_nxt;
    w_gnt1_nxt  = w_busy_nxt &  w_owner_nxt;
    w_done0_nxt = (w_state_nxt == S_DONE) & ~w_owner_nxt;
    w_done1_nxt = (w_state_nxt == S_DONE) &  w_owner_nxt;
  end

  // Status output registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_gnt0  <= w_gnt0_nxt;
      r_gnt1  <= w_gnt1_nxt;
      r_done0 <= w_done0_nxt;
      r_done1 <= w_done1_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Datapath: operand capture at the grant, byte-serial accumulation during
  // BUSY, pointer hand-over in DONE.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ptr    <= 1'b0;
      r_owner  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_owner <= w_pick;
            r_a     <= w_pick ? A1 : A0;
            r_b     <= w_pick ? B1 : B0;
            r_carry <= w_pick ? Cin1 : Cin0;
            r_cnt   <= '0;
          end
        end
        S_BUSY: begin
          r_result <= f_put_byte(r_result, r_cnt, AddS);
          r_carry  <= AddCout;
          r_cnt    <= r_cnt + CW'(1);
          // CoutOut changes only when the final byte finishes, so the
          // previous carry stays on CoutOut while bytes are accumulating.
          if (r_cnt == LAST_IDX) begin
            r_cout <= AddCout;
          end
        end
        S_DONE: begin
          r_ptr <= ~r_owner;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Feed the current byte slice to the external adder. Outside BUSY it sees zeros.
  always_comb begin
    if (r_state == S_BUSY) begin
      AddA   = f_get_byte(r_a, r_cnt);
      AddB   = f_get_byte(r_b, r_cnt);
      AddCin = r_carry;
    end else begin
      AddA   = 8'd0;
      AddB   = 8'd0;
      AddCin = 1'b0;
    end
  end

  assign Gnt0    = r_gnt0;
  assign Gnt1    = r_gnt1;
  assign Done0   = r_done0;
  assign Done1   = r_done1;
  assign Busy    = r_busy;
  assign Result  = r_result;
  assign CoutOut = r_cout;

endmodule
